// File: rtl/sprite_ram_ctrl.sv
// Sprite RAM controller: renders a 2**(ADDR_WIDTH/2)-square sprite and owns the RAM write port.
// Latency: x,y -> spr_on/spr_color in 2 cycles; host write -> RAM write port in 1 cycle; fill takes 2**ADDR_WIDTH cycles.
// Backpressure: host_ready drops while fill_start is asserted and during a fill; render path never stalls.
//
// Ports:
//   clk, reset               clock and async active-high reset
//   frame_start              latches org_x/org_y (and mirror) for the coming frame
//   org_x, org_y, x, y       sprite origin and current scan position (10-bit pixels)
//   video_on                 scan is in the visible area
//   mirror                   horizontal flip, honoured only when SPRITE_MIRROR_EN is defined
//   ram_addr_r / ram_dout    RAM read port (1-cycle read latency)
//   ram_we/addr_w/din        RAM write port (registered)
//   spr_on, spr_color        opaque-pixel flag and color index
//   host_valid/addr/data,    single-entry host write handshake
//   host_ready
//   fill_start, fill_color,  bulk fill of the whole RAM with one color
//   fill_busy, fill_done
// Build option: define SPRITE_MIRROR_EN to enable horizontal mirroring.
module sprite_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [9:0]            org_x,
  input  logic [9:0]            org_y,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  video_on,
  input  logic                  mirror,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  spr_on,
  output logic [DATA_WIDTH-1:0] spr_color,
  input  logic                  host_valid,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ready,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam int                  HALF = ADDR_WIDTH / 2;
  localparam logic [9:0]          SIDE = 10'(1 << HALF);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  // ---------------- render path ----------------
  logic [9:0] org_x_lat, org_y_lat;
  logic [9:0] col, row;
  logic       hit, hit_d;
  logic [HALF-1:0] col_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      org_x_lat <= '0;
      org_y_lat <= '0;
    end else if (frame_start) begin
      org_x_lat <= org_x;
      org_y_lat <= org_y;
    end
  end

  // Unsigned wrap makes pixels left/above the origin land far above SIDE, so one compare suffices.
  assign col = x - org_x_lat;
  assign row = y - org_y_lat;
  assign hit = video_on && (col < SIDE) && (row < SIDE);

`ifdef SPRITE_MIRROR_EN
  logic mirror_lat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            mirror_lat <= 1'b0;
    else if (frame_start) mirror_lat <= mirror;
  end
  // (SIDE-1) - c equals the bitwise inverse of c over HALF bits.
  assign col_idx = mirror_lat ? ~col[HALF-1:0] : col[HALF-1:0];
`else
  logic mirror_unused;
  assign mirror_unused = mirror;
  assign col_idx = col[HALF-1:0];
`endif

  assign ram_addr_r = {row[HALF-1:0], col_idx};

  // hit is delayed one cycle to line up with ram_dout, then the result is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d     <= 1'b0;
      spr_on    <= 1'b0;
      spr_color <= '0;
    end else begin
      hit_d     <= hit;
      spr_on    <= hit_d && (ram_dout != '0);
      spr_color <= (hit_d && (ram_dout != '0)) ? ram_dout : '0;
    end
  end

  // ---------------- write FSM ----------------
  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic                  we_d, done_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d, color_q, color_d;

  // ram_addr_w doubles as the fill counter: during FILL it always holds the address being written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_we     <= 1'b0;
      ram_addr_w <= '0;
      ram_din    <= '0;
      fill_done  <= 1'b0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      ram_we     <= we_d;
      ram_addr_w <= addr_d;
      ram_din    <= din_d;
      fill_done  <= done_d;
      color_q    <= color_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = 1'b0;
    addr_d     = ram_addr_w;
    din_d      = ram_din;
    done_d     = 1'b0;
    color_d    = color_q;
    host_ready = 1'b0;
    fill_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        host_ready = !fill_start;
        if (fill_start) begin
          state_d = FILL;
          color_d = fill_color;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = fill_color;
        end else if (host_valid) begin
          we_d   = 1'b1;
          addr_d = host_addr;
          din_d  = host_data;
        end
      end
      FILL: begin
        fill_busy = 1'b1;
        if (ram_addr_w == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = ram_addr_w + 1'b1;
          din_d  = color_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_ram_ctrl.sv
module tb_sprite_ram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic [9:0] org_x, org_y, x, y;
  logic       video_on, mirror;
  logic [9:0] ram_addr_r;
  logic [1:0] ram_dout;
  logic       ram_we;
  logic [9:0] ram_addr_w;
  logic [1:0] ram_din;
  logic       spr_on;
  logic [1:0] spr_color;
  logic       host_valid;
  logic [9:0] host_addr;
  logic [1:0] host_data;
  logic       host_ready;
  logic       fill_start;
  logic [1:0] fill_color;
  logic       fill_busy, fill_done;

  int passed = 0;
  int total  = 0;

  logic [1:0] mem [1024];

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= ram_din;
    ram_dout <= mem[ram_addr_r];
  end

  sprite_ram_ctrl dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .org_x(org_x), .org_y(org_y), .x(x), .y(y),
    .video_on(video_on), .mirror(mirror),
    .ram_addr_r(ram_addr_r), .ram_dout(ram_dout),
    .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din),
    .spr_on(spr_on), .spr_color(spr_color),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({ram_we, ram_addr_w, ram_din} !== 13'd0) $display("FAIL reset_wr we/addr/din=%b/%0d/%0d want 0/0/0", ram_we, ram_addr_w, ram_din); else passed++;
    total++; if ({spr_on, spr_color} !== 3'd0) $display("FAIL reset_spr on/color=%b/%0d want 0/0", spr_on, spr_color); else passed++;
    total++; if ({fill_busy, fill_done} !== 2'b00) $display("FAIL reset_fill busy/done=%b%b want 00", fill_busy, fill_done); else passed++;
    total++; if (host_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", host_ready); else passed++;
    total++; if (ram_addr_r !== 10'd0) $display("FAIL reset_org ram_addr_r got %0d want 0", ram_addr_r); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic host_write(input logic [9:0] a, input logic [1:0] d);
    @(negedge clk);
    host_valid = 1'b1; host_addr = a; host_data = d;
    #1;
    total++; if (host_ready !== 1'b1) $display("FAIL hw_ready addr %0d got %b want 1", a, host_ready); else passed++;
    @(negedge clk);
    host_valid = 1'b0;
    total++; if ({ram_we, ram_addr_w, ram_din} !== {1'b1, a, d})
      $display("FAIL hw_port we/addr/din=%b/%0d/%0d want 1/%0d/%0d", ram_we, ram_addr_w, ram_din, a, d); else passed++;
    @(negedge clk);
    total++; if (ram_we !== 1'b0) $display("FAIL hw_idle_we got %b want 0", ram_we); else passed++;
  endtask

  task automatic test_host_write();
    host_write(10'd0,   2'd2);
    host_write(10'd33,  2'd0);
    host_write(10'd31,  2'd1);
    host_write(10'd992, 2'd3);
  endtask

  task automatic pulse_frame(input logic [9:0] ox, input logic [9:0] oy, input logic m);
    @(negedge clk);
    org_x = ox; org_y = oy; mirror = m; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_render();
    logic [9:0] vx [9] = '{10'd100, 10'd100, 10'd132, 10'd101, 10'd131, 10'd100, 10'd99, 10'd100, 10'd131};
    logic [9:0] vy [9] = '{10'd50,  10'd50,  10'd50,  10'd51,  10'd50,  10'd81,  10'd50, 10'd82,  10'd50};
    logic       vv [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eo [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] ec [9] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0};
    pulse_frame(10'd100, 10'd50, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if ({spr_on, spr_color} !== {eo[i-2], ec[i-2]})
          $display("FAIL render_v%0d on/color=%b/%0d want %b/%0d", i-2, spr_on, spr_color, eo[i-2], ec[i-2]);
        else passed++;
      end
      if (i < 9) begin
        x = vx[i]; y = vy[i]; video_on = vv[i];
      end else video_on = 1'b0;
    end
  endtask

  task automatic test_origin_latch();
    pulse_frame(10'd100, 10'd50, 1'b0);
    @(negedge clk);
    org_x = 10'd0; org_y = 10'd0;
    x = 10'd100; y = 10'd50;
    #1;
    total++; if (ram_addr_r !== 10'd0) $display("FAIL midframe_addr got %0d want 0", ram_addr_r); else passed++;
    pulse_frame(10'd0, 10'd0, 1'b0);
    @(negedge clk);
    #1;
    // row 50 -> 18, col 100 -> 4
    total++; if (ram_addr_r !== 10'd580) $display("FAIL newframe_addr got %0d want 580", ram_addr_r); else passed++;
  endtask

  task automatic test_mirror();
    pulse_frame(10'd200, 10'd10, 1'b1);
    @(negedge clk);
    x = 10'd200; y = 10'd12;
    #1;
`ifdef SPRITE_MIRROR_EN
    total++; if (ram_addr_r !== 10'd95) $display("FAIL mirror_col got %0d want 95", ram_addr_r); else passed++;
`else
    total++; if (ram_addr_r !== 10'd64) $display("FAIL mirror_ignored got %0d want 64", ram_addr_r); else passed++;
`endif
    pulse_frame(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_fill_priority();
    int bad;
    bad = 0;
    @(negedge clk);
    fill_start = 1'b1; fill_color = 2'd3;
    host_valid = 1'b1; host_addr = 10'd5; host_data = 2'd1;
    #1;
    total++; if (host_ready !== 1'b0) $display("FAIL fill_start_ready got %b want 0", host_ready); else passed++;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (k == 0)  fill_start = 1'b0;
      if (k == 10) begin fill_start = 1'b1; fill_color = 2'd1; end
      if (k == 11) fill_start = 1'b0;
      #1;
      if (bad == 0 && ({ram_we, ram_addr_w, ram_din, host_ready, fill_busy, fill_done} !== {1'b1, 10'(k), 2'd3, 1'b0, 1'b1, 1'b0})) begin
        $display("FAIL fill_cycle k=%0d we/addr/din/rdy/busy/done=%b/%0d/%0d/%b/%b/%b want 1/%0d/3/0/1/0",
                 k, ram_we, ram_addr_w, ram_din, host_ready, fill_busy, fill_done, k);
        bad = 1;
      end
    end
    total++; if (bad != 0) $display("FAIL fill_sequence got bad=%0d want 0", bad); else passed++;
    @(negedge clk);
    #1;
    total++; if ({fill_done, ram_we, fill_busy, host_ready} !== 4'b1001)
      $display("FAIL fill_done_cycle done/we/busy/rdy=%b%b%b%b want 1001", fill_done, ram_we, fill_busy, host_ready); else passed++;
    @(negedge clk);
    host_valid = 1'b0;
    total++; if ({ram_we, ram_addr_w, ram_din, fill_done} !== {1'b1, 10'd5, 2'd1, 1'b0})
      $display("FAIL post_fill_host we/addr/din/done=%b/%0d/%0d/%b want 1/5/1/0", ram_we, ram_addr_w, ram_din, fill_done); else passed++;
    @(negedge clk);
    total++; if ({mem[10'd0], mem[10'd1023], mem[10'd5]} !== {2'd3, 2'd3, 2'd1})
      $display("FAIL fill_contents m0/m1023/m5=%0d/%0d/%0d want 3/3/1", mem[10'd0], mem[10'd1023], mem[10'd5]); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int found, bad;
    found = 0; bad = 0;
    @(negedge clk);
    fill_start = 1'b1; fill_color = 2'd2;
    for (int k = 0; k < 1100 && found == 0; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      if (ram_we && ram_addr_w == 10'd500) found = 1;
    end
    total++; if (found != 1) $display("FAIL abort_reach500 got found=%0d want 1", found); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({ram_we, fill_busy, fill_done} !== 3'b000)
      $display("FAIL abort_now we/busy/done=%b%b%b want 000", ram_we, fill_busy, fill_done); else passed++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (host_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", host_ready); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (fill_done !== 1'b0 || ram_we !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL abort_quiet got %0d bad cycles want 0", bad); else passed++;
    total++; if ({mem[10'd499], mem[10'd500], mem[10'd501]} !== {2'd2, 2'd3, 2'd3})
      $display("FAIL abort_partial m499/m500/m501=%0d/%0d/%0d want 2/3/3", mem[10'd499], mem[10'd500], mem[10'd501]); else passed++;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0;
    org_x = '0; org_y = '0; x = '0; y = '0; video_on = 1'b0; mirror = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;
    fill_start = 1'b0; fill_color = '0;
    test_reset();
    test_host_write();
    test_render();
    test_origin_latch();
    test_mirror();
    test_fill_priority();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
